// File: rtl/cpu_types_pkg.sv
// Shared types for the multi-core memory/coherence controller.
// Bus word, RAM port status and controller FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      ACCESS,
      ERROR
   } ramstate_t;

   typedef enum logic [2:0] {
      IDLE,
      IFETCH,
      DREAD,
      DWRITE,
      SNOOP,
      C2C
   } busctl_state_t;

   // Width of a CPU id; a single core still needs one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_control_if.sv
// Cache-side and RAM-side lanes of the coherence controller.
// cc = controller view, cpu = cache/RAM model view.
interface cache_control_if
   import cpu_types_pkg::*;
#(
   parameter int CPUS = 2
);

   logic [CPUS-1:0] iREN, iwait;
   word_t           iaddr [CPUS];
   word_t           iload [CPUS];

   logic [CPUS-1:0] dREN, dWEN, dwait;
   word_t           daddr  [CPUS];
   word_t           dstore [CPUS];
   word_t           dload  [CPUS];

   logic [CPUS-1:0] ccwrite, cctrans;
   logic [CPUS-1:0] ccwait, ccinv;
   word_t           ccsnoopaddr [CPUS];

   logic            ramREN, ramWEN;
   word_t           ramaddr, ramstore, ramload;
   ramstate_t       ramstate;

   modport cc (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore,
      input  ccwrite, cctrans, ramload, ramstate,
      output iwait, iload, dwait, dload,
      output ccwait, ccinv, ccsnoopaddr,
      output ramREN, ramWEN, ramaddr, ramstore
   );

   modport cpu (
      output iREN, iaddr, dREN, dWEN, daddr, dstore,
      output ccwrite, cctrans, ramload, ramstate,
      input  iwait, iload, dwait, dload,
      input  ccwait, ccinv, ccsnoopaddr,
      input  ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/rr_picker.sv
// Round-robin picker: first requesting id at or after i_ptr.
// Scanned high-to-low so the nearest id overwrites the rest.
module rr_picker #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic          o_valid,
   output logic [PW-1:0] o_id
);

   int w_idx;

   always_comb begin
      o_valid = |i_req;
      o_id    = '0;
      w_idx   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = (int'(i_ptr) + k) % N;
         if (i_req[w_idx[PW-1:0]]) o_id = w_idx[PW-1:0];
      end
   end

endmodule

// File: rtl/bus_coherence_ctrl.sv
// N-core RAM arbiter with snoop broadcast and cache-to-cache
// supply; SNOOP_EN=0 degrades it to a plain round-robin arbiter.
module bus_coherence_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CPUS     = 2,
   parameter bit SNOOP_EN = 1'b1
) (
   input logic        CLK,
   input logic        nRST,
   cache_control_if.cc ccif
);

   localparam int PW = ptr_w(CPUS);

   busctl_state_t   r_state;
   logic [PW-1:0]   r_gnt, r_src, r_irr, r_drr;

   logic            w_ivld, w_dvld, w_live, w_acc, w_done;
   logic            w_allresp, w_hit;
   logic [PW-1:0]   w_iid, w_did, w_src, w_nxt;
   logic [CPUS-1:0] w_mask, w_dirty;

   logic [CPUS-1:0] w_iwait, w_dwait, w_ccwait, w_ccinv;
   word_t           w_iload [CPUS];
   word_t           w_dload [CPUS];
   word_t           w_snpad [CPUS];

   rr_picker #(.N(CPUS), .PW(PW)) u_ipick (
      .i_req   (ccif.iREN),
      .i_ptr   (r_irr),
      .o_valid (w_ivld),
      .o_id    (w_iid)
   );

   rr_picker #(.N(CPUS), .PW(PW)) u_dpick (
      .i_req   (ccif.dREN | ccif.dWEN),
      .i_ptr   (r_drr),
      .o_valid (w_dvld),
      .o_id    (w_did)
   );

   assign w_acc  = (ccif.ramstate == ACCESS);
   assign w_nxt  = (r_gnt == PW'(CPUS - 1)) ? '0 : r_gnt + 1'b1;
   assign w_mask = ~(CPUS'(1) << r_gnt);
   assign w_dirty   = ccif.dWEN & w_mask;
   assign w_allresp = ((ccif.cctrans & w_mask) == w_mask);
   assign w_done    = w_live & w_acc;

   always_comb begin
      w_hit = 1'b0;
      w_src = '0;
      for (int o = CPUS - 1; o >= 0; o--) begin
         if (w_dirty[o]) begin
            w_hit = 1'b1;
            w_src = PW'(o);
         end
      end
   end

   // Grantee still holding the request it was granted for.
   always_comb begin
      unique case (r_state)
         IFETCH:            w_live = ccif.iREN[r_gnt];
         DWRITE:            w_live = ccif.dWEN[r_gnt];
         DREAD, SNOOP, C2C: w_live = ccif.dREN[r_gnt];
         default:           w_live = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_src   <= '0;
         r_irr   <= '0;
         r_drr   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_dvld) begin
                  r_gnt <= w_did;
                  if (ccif.dWEN[w_did])
                     r_state <= DWRITE;
                  else if (SNOOP_EN && ccif.cctrans[w_did])
                     r_state <= SNOOP;
                  else
                     r_state <= DREAD;
               end else if (w_ivld) begin
                  r_gnt   <= w_iid;
                  r_state <= IFETCH;
               end
            end
            SNOOP: begin
               if (!w_live) begin
                  r_state <= IDLE;
               end else if (w_allresp) begin
                  r_src   <= w_src;
                  r_state <= w_hit ? C2C : DREAD;
               end
            end
            default: begin
               if (!w_live) begin
                  r_state <= IDLE;
               end else if (w_acc) begin
                  r_state <= IDLE;
                  if (r_state == IFETCH) r_irr <= w_nxt;
                  else                   r_drr <= w_nxt;
               end
            end
         endcase
      end
   end

   always_comb begin
      w_iwait  = '1;
      w_dwait  = '1;
      w_ccwait = '0;
      w_ccinv  = '0;
      for (int i = 0; i < CPUS; i++) begin
         w_iload[i] = '0;
         w_dload[i] = '0;
         w_snpad[i] = '0;
      end
      ccif.ramREN   = 1'b0;
      ccif.ramWEN   = 1'b0;
      ccif.ramaddr  = '0;
      ccif.ramstore = '0;
      unique case (r_state)
         IFETCH: begin
            ccif.ramREN    = 1'b1;
            ccif.ramaddr   = ccif.iaddr[r_gnt];
            w_iload[r_gnt] = ccif.ramload;
            if (w_done) w_iwait[r_gnt] = 1'b0;
         end
         DREAD: begin
            ccif.ramREN    = 1'b1;
            ccif.ramaddr   = ccif.daddr[r_gnt];
            w_dload[r_gnt] = ccif.ramload;
            if (w_done) w_dwait[r_gnt] = 1'b0;
         end
         DWRITE: begin
            ccif.ramWEN   = 1'b1;
            ccif.ramaddr  = ccif.daddr[r_gnt];
            ccif.ramstore = ccif.dstore[r_gnt];
            if (w_done) w_dwait[r_gnt] = 1'b0;
         end
         SNOOP: begin
            for (int o = 0; o < CPUS; o++) begin
               if (PW'(o) != r_gnt) begin
                  w_ccwait[o] = 1'b1;
                  w_ccinv[o]  = ccif.ccwrite[r_gnt];
                  w_snpad[o]  = ccif.daddr[r_gnt];
               end
            end
         end
         C2C: begin
            ccif.ramWEN     = 1'b1;
            ccif.ramaddr    = ccif.daddr[r_gnt];
            ccif.ramstore   = ccif.dstore[r_src];
            w_dload[r_gnt]  = ccif.dstore[r_src];
            w_ccwait[r_src] = 1'b1;
            if (w_done) begin
               w_dwait[r_gnt] = 1'b0;
               w_dwait[r_src] = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign ccif.iwait       = w_iwait;
   assign ccif.dwait       = w_dwait;
   assign ccif.iload       = w_iload;
   assign ccif.dload       = w_dload;
   assign ccif.ccwait      = w_ccwait;
   assign ccif.ccinv       = w_ccinv;
   assign ccif.ccsnoopaddr = w_snpad;

endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// Directed bench: a coherent 2-core controller and a
// non-coherent 4-core controller sharing clock and reset.
module tb_bus_coherence_ctrl;
   import cpu_types_pkg::*;

   logic clk;
   logic nrst;
   int   n_chk;
   int   n_err;

   cache_control_if #(.CPUS(2)) a ();
   cache_control_if #(.CPUS(4)) b ();

   bus_coherence_ctrl #(.CPUS(2), .SNOOP_EN(1'b1)) u_a (
      .CLK  (clk),
      .nRST (nrst),
      .ccif (a)
   );

   bus_coherence_ctrl #(.CPUS(4), .SNOOP_EN(1'b0)) u_b (
      .CLK  (clk),
      .nRST (nrst),
      .ccif (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      nrst  = 1'b0;
      a.iREN = '0; a.dREN = '0; a.dWEN = '0;
      a.ccwrite = '0; a.cctrans = '0;
      a.ramload = '0; a.ramstate = FREE;
      b.iREN = '0; b.dREN = '0; b.dWEN = '0;
      b.ccwrite = '0; b.cctrans = '0;
      b.ramload = '0; b.ramstate = FREE;
      for (int i = 0; i < 2; i++) begin
         a.iaddr[i] = '0; a.daddr[i] = '0; a.dstore[i] = '0;
      end
      for (int i = 0; i < 4; i++) begin
         b.iaddr[i] = '0; b.daddr[i] = '0; b.dstore[i] = '0;
      end
      #3;
      chk("rst_iwait", 32'(a.iwait), 32'h3);
      chk("rst_dwait", 32'(a.dwait), 32'h3);
      chk("rst_ramen", 32'({a.ramREN, a.ramWEN}), 32'h0);

      // two fetchers, RAM always ready
      #5;
      nrst = 1'b1;
      a.iREN = 2'b11;
      a.iaddr[0] = 32'h40;
      a.iaddr[1] = 32'h80;
      a.ramload = 32'h1111;
      a.ramstate = ACCESS;
      #1;
      chk("idle_iwait", 32'(a.iwait), 32'h3);
      chk("idle_ramren", 32'(a.ramREN), 32'h0);
      nxt();
      chk("if0_iwait", 32'(a.iwait), 32'h2);
      chk("if0_ramren", 32'(a.ramREN), 32'h1);
      chk("if0_addr", a.ramaddr, 32'h40);
      chk("if0_iload", a.iload[0], 32'h1111);
      nxt();
      chk("gap_iwait", 32'(a.iwait), 32'h3);
      nxt();
      chk("if1_iwait", 32'(a.iwait), 32'h1);
      chk("if1_addr", a.ramaddr, 32'h80);
      nxt();
      nxt();
      chk("if0b_iwait", 32'(a.iwait), 32'h2);
      nxt();
      a.iREN = '0;

      // data beats instruction
      a.iREN = 2'b01;
      a.dREN = 2'b10;
      a.daddr[1] = 32'h200;
      a.ramload = 32'h2222;
      nxt();
      chk("dr_dwait", 32'(a.dwait), 32'h1);
      chk("dr_iwait", 32'(a.iwait), 32'h3);
      chk("dr_addr", a.ramaddr, 32'h200);
      chk("dr_dload", a.dload[1], 32'h2222);
      nxt();
      a.dREN = '0;
      nxt();
      chk("dr_if_iwait", 32'(a.iwait), 32'h2);
      chk("dr_if_addr", a.ramaddr, 32'h40);
      nxt();
      a.iREN = '0;

      // snoop with dirty responder
      a.dREN = 2'b01;
      a.cctrans = 2'b01;
      a.ccwrite = 2'b01;
      a.daddr[0] = 32'h100;
      nxt();
      chk("sn_ccwait", 32'(a.ccwait), 32'h2);
      chk("sn_ccinv", 32'(a.ccinv), 32'h2);
      chk("sn_addr", a.ccsnoopaddr[1], 32'h100);
      chk("sn_ramen", 32'({a.ramREN, a.ramWEN}), 32'h0);
      chk("sn_dwait", 32'(a.dwait), 32'h3);
      nxt();
      chk("sn_hold", 32'(a.ccwait), 32'h2);
      a.cctrans = 2'b11;
      a.dWEN = 2'b10;
      a.daddr[1] = 32'h100;
      a.dstore[1] = 32'hDEADBEEF;
      nxt();
      chk("c2c_ramen", 32'({a.ramREN, a.ramWEN}), 32'h1);
      chk("c2c_store", a.ramstore, 32'hDEADBEEF);
      chk("c2c_dload", a.dload[0], 32'hDEADBEEF);
      chk("c2c_addr", a.ramaddr, 32'h100);
      chk("c2c_dwait", 32'(a.dwait), 32'h0);
      chk("c2c_ccwait", 32'(a.ccwait), 32'h2);
      nxt();
      a.dREN = '0; a.dWEN = '0;
      a.cctrans = '0; a.ccwrite = '0;

      // snoop with clean responder
      a.dREN = 2'b01;
      a.cctrans = 2'b01;
      a.daddr[0] = 32'h140;
      nxt();
      chk("sc_ccinv", 32'(a.ccinv), 32'h0);
      chk("sc_ccwait", 32'(a.ccwait), 32'h2);
      a.cctrans = 2'b11;
      a.ramstate = BUSY;
      a.ramload = 32'h3333;
      nxt();
      chk("sc_ramen", 32'({a.ramREN, a.ramWEN}), 32'h2);
      chk("sc_busy_dwait", 32'(a.dwait), 32'h3);
      chk("sc_dload", a.dload[0], 32'h3333);
      chk("sc_ccwait", 32'(a.ccwait), 32'h0);
      a.ramstate = ACCESS;
      #1;
      chk("sc_dwait", 32'(a.dwait), 32'h2);
      nxt();
      a.dREN = '0;
      a.cctrans = '0;

      // reset during a stalled write
      a.dWEN = 2'b10;
      a.daddr[1] = 32'h300;
      a.dstore[1] = 32'hCAFEF00D;
      a.ramstate = BUSY;
      nxt();
      chk("dw_ramwen", 32'(a.ramWEN), 32'h1);
      chk("dw_store", a.ramstore, 32'hCAFEF00D);
      chk("dw_dwait", 32'(a.dwait), 32'h3);
      nxt();
      chk("dw_hold", 32'(a.ramWEN), 32'h1);
      nrst = 1'b0;
      #1;
      chk("ar_ramwen", 32'(a.ramWEN), 32'h0);
      chk("ar_waits", 32'({a.iwait, a.dwait}), 32'hF);
      #1;
      nrst = 1'b1;
      a.ramstate = ACCESS;
      nxt();
      chk("dw2_dwait", 32'(a.dwait), 32'h1);
      chk("dw2_addr", a.ramaddr, 32'h300);
      nxt();
      a.dWEN = '0;

      // grantee abandons its read
      a.dREN = 2'b01;
      a.daddr[0] = 32'h180;
      a.ramstate = BUSY;
      nxt();
      chk("ab_ramren", 32'(a.ramREN), 32'h1);
      a.dREN = '0;
      a.ramstate = ACCESS;
      #1;
      chk("ab_dwait", 32'(a.dwait), 32'h3);
      nxt();
      chk("ab_idle", 32'(a.ramREN), 32'h0);

      // four non-coherent data readers
      b.dREN = 4'hF;
      b.cctrans = 4'hF;
      for (int i = 0; i < 4; i++) b.daddr[i] = 32'h10 * (i + 1);
      b.ramstate = ACCESS;
      for (int k = 0; k < 5; k++) begin
         int g;
         logic [3:0] e;
         g = k % 4;
         e = ~(4'b0001 << g);
         nxt();
         chk($sformatf("nc_dwait%0d", k), 32'(b.dwait), 32'(e));
         chk($sformatf("nc_addr%0d", k), b.ramaddr, 32'h10 * (g + 1));
         chk($sformatf("nc_ccwait%0d", k), 32'(b.ccwait), 32'h0);
         nxt();
         chk($sformatf("nc_gap%0d", k), 32'(b.dwait), 32'hF);
      end
      b.dREN = '0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
